// File: rtl/cpu_mem_pkg.sv
// =============================================================================
// cpu_mem_pkg : shared types and widths for the CPU memory port and RAM
// Revision    : 1.0
// =============================================================================
`default_nettype none

package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } mem_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// =============================================================================
// mem_port_arbiter : shares the single-port RAM between fetch and load/store
// Revision         : 1.0
// =============================================================================
`default_nettype none

module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = CPU_ADDR_W,
    parameter int DATA_W       = CPU_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int MAX_LS_BURST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              en_ram,
    output logic              wen_ram,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int c_STREAK_W = $clog2(MAX_LS_BURST + 1);
    localparam int c_CNT_W    = 2;
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_LS_BURST);
    localparam logic [c_CNT_W-1:0]    c_WAIT_LOAD  = c_CNT_W'(RD_LAT - 1);

    mem_state_t              r_state;
    logic                    r_we;
    logic [c_STREAK_W-1:0]   r_streak;
    logic [c_CNT_W-1:0]      r_cnt;

    logic                    w_pick_ls;
    logic                    w_any_req;

    // LS has priority unless it has starved a waiting fetch for a full burst
    always_comb begin
        w_pick_ls = ls_req;
        if (ls_req && if_req) begin
            w_pick_ls = (r_streak != c_STREAK_MAX);
        end
    end

    assign w_any_req = if_req | ls_req;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_streak  <= '0;
            r_cnt     <= '0;
            owner     <= OWN_IF;
            en_ram    <= 1'b0;
            wen_ram   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            // RAM strobes and acks are single-cycle pulses
            en_ram    <= 1'b0;
            wen_ram   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            ls_ack    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ACCESS;
                        owner     <= w_pick_ls ? OWN_LS : OWN_IF;
                        r_we      <= w_pick_ls & ls_we;
                        en_ram    <= 1'b1;
                        wen_ram   <= w_pick_ls & ls_we;
                        ram_addr  <= w_pick_ls ? ls_addr : if_addr;
                        ram_wdata <= w_pick_ls ? ls_wdata : '0;
                        if (!w_pick_ls) begin
                            r_streak <= '0;
                        end else if (if_req && (r_streak != c_STREAK_MAX)) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (r_we) begin
                        r_state <= RESP;
                        ls_ack  <= 1'b1;
                    end else begin
                        r_state <= WAIT;
                        r_cnt   <= c_WAIT_LOAD;
                    end
                end

                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        if (owner == OWN_LS) begin
                            ls_rdata <= ram_rdata;
                            ls_ack   <= 1'b1;
                        end else begin
                            if_rdata <= ram_rdata;
                            if_ack   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter (RD_LAT 1 and 3)
// Revision            : 1.0
// =============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    typedef struct packed {
        logic        own;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // RD_LAT=1 instance
    logic        if_req, if_ack, ls_req, ls_we, ls_ack, en_ram, wen_ram, busy, owner;
    logic [7:0]  if_addr, ls_addr, ram_addr;
    logic [15:0] if_rdata, ls_wdata, ls_rdata, ram_wdata, ram_rdata;

    // RD_LAT=3 instance
    logic        if_req3, if_ack3, ls_req3, ls_we3, ls_ack3, en_ram3, wen_ram3, busy3, owner3;
    logic [7:0]  if_addr3, ls_addr3, ram_addr3;
    logic [15:0] if_rdata3, ls_wdata3, ls_rdata3, ram_wdata3, ram_rdata3;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t e_mon;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1), .MAX_LS_BURST(3)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .en_ram(en_ram), .wen_ram(wen_ram), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(3), .MAX_LS_BURST(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_ack(ls_ack3), .ls_rdata(ls_rdata3),
        .en_ram(en_ram3), .wen_ram(wen_ram3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .busy(busy3), .owner(owner3)
    );

    function automatic logic [15:0] pat(input logic [7:0] a);
        if (a == 8'h10) return 16'hA5C3;
        if (a == 8'h05) return 16'hBEEF;
        return {a, a ^ 8'h5A};
    endfunction

    // RAM model: data valid RD_LAT cycles after the en_ram cycle, 0xDEAD otherwise
    logic [15:0] mem [256];
    logic        mem_init = 1'b0;
    logic [3:0]  v1 = '0;
    logic [3:0]  v3 = '0;
    logic [15:0] d1 [4];
    logic [15:0] d3 [4];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
            mem_init <= 1'b1;
        end else if (en_ram && wen_ram) begin
            mem[ram_addr] <= ram_wdata;
        end
        v1    <= {v1[2:0], en_ram & ~wen_ram};
        v3    <= {v3[2:0], en_ram3 & ~wen_ram3};
        d1[0] <= mem[ram_addr];
        d3[0] <= mem[ram_addr3];
        for (int k = 1; k < 4; k++) begin
            d1[k] <= d1[k-1];
            d3[k] <= d3[k-1];
        end
    end

    assign ram_rdata  = v1[0] ? d1[0] : 16'hDEAD;
    assign ram_rdata3 = v3[2] ? d3[2] : 16'hDEAD;

    // Scoreboard monitor for the RD_LAT=1 instance
    always @(negedge clk) begin
        if (rst) begin
            if (if_ack || ls_ack) begin
                checks++;
                if (if_ack && ls_ack) begin
                    errors++;
                    $display("FAIL ack_overlap: if_ack=%b ls_ack=%b, required at most one", if_ack, ls_ack);
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack: if_ack=%b ls_ack=%b with empty queue", if_ack, ls_ack);
                end else begin
                    e_mon = sb.pop_front();
                    if (ls_ack !== e_mon.own || (ls_ack ? ls_rdata : if_rdata) !== e_mon.data) begin
                        errors++;
                        $display("FAIL sb_ack: owner=%b data=%h, required owner=%b data=%h",
                                 ls_ack, (ls_ack ? ls_rdata : if_rdata), e_mon.own, e_mon.data);
                    end
                end
            end
            if (en_ram && owner == OWN_IF) begin
                checks++;
                if (wen_ram !== 1'b0) begin
                    errors++;
                    $display("FAIL if_wen: wen_ram=%b on fetch access, required 0", wen_ram);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        if_req3 = 0; if_addr3 = 0; ls_req3 = 0; ls_we3 = 0; ls_addr3 = 0; ls_wdata3 = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, en_ram, wen_ram, if_ack, ls_ack, owner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/en/wen/ifack/lsack/owner=%b, required 000000",
                     {busy, en_ram, wen_ram, if_ack, ls_ack, owner});
        end
        checks++;
        if ({ram_addr, ram_wdata, if_rdata, ls_rdata} !== 56'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h ifr=%h lsr=%h, required all 0",
                     ram_addr, ram_wdata, if_rdata, ls_rdata);
        end
        checks++;
        if (dut1.r_streak !== 2'd0) begin
            errors++;
            $display("FAIL reset_streak: streak=%0d, required 0", dut1.r_streak);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_if_read();
        if_addr = 8'h10; if_req = 1'b1;
        sb.push_back('{own: OWN_IF, data: 16'hA5C3});
        @(negedge clk);
        checks++;
        if ({en_ram, wen_ram, busy, owner} !== 4'b1010 || ram_addr !== 8'h10) begin
            errors++;
            $display("FAIL if_read_access: en/wen/busy/owner=%b addr=%h, required 1010 addr=10",
                     {en_ram, wen_ram, busy, owner}, ram_addr);
        end
        @(negedge clk);
        checks++;
        if ({en_ram, if_ack, ls_ack} !== 3'b000) begin
            errors++;
            $display("FAIL if_read_wait: en/ifack/lsack=%b, required 000", {en_ram, if_ack, ls_ack});
        end
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 16'hA5C3) begin
            errors++;
            $display("FAIL if_read_ack: if_ack=%b if_rdata=%h, required 1 A5C3", if_ack, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL if_read_done: busy=%b if_ack=%b, required 0 0", busy, if_ack);
        end
    endtask

    task automatic test_ls_load(input logic [7:0] a, input logic [15:0] d);
        int n;
        ls_addr = a; ls_we = 1'b0; ls_req = 1'b1;
        sb.push_back('{own: OWN_LS, data: d});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ls_ack && n < 12);
        checks++;
        if (ls_ack !== 1'b1 || n != 3) begin
            errors++;
            $display("FAIL ls_load_latency: ack after %0d cycles (ack=%b), required 3", n, ls_ack);
        end
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ls_store();
        ls_addr = 8'h2F; ls_we = 1'b1; ls_wdata = 16'h1234; ls_req = 1'b1;
        sb.push_back('{own: OWN_LS, data: pat(8'h20)});
        @(negedge clk);
        checks++;
        if ({en_ram, wen_ram, owner} !== 3'b111 || ram_addr !== 8'h2F || ram_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL store_access: en/wen/owner=%b addr=%h wdata=%h, required 111 2F 1234",
                     {en_ram, wen_ram, owner}, ram_addr, ram_wdata);
        end
        @(negedge clk);
        checks++;
        if (ls_ack !== 1'b1 || ls_rdata !== pat(8'h20)) begin
            errors++;
            $display("FAIL store_ack: ls_ack=%b ls_rdata=%h, required 1 %h", ls_ack, ls_rdata, pat(8'h20));
        end
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 16'h0;
        @(negedge clk);
        checks++;
        if ({en_ram, wen_ram} !== 2'b00 || ram_addr !== 8'h0 || ram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL store_idle_outputs: en/wen=%b addr=%h wdata=%h, required 00 0 0",
                     {en_ram, wen_ram}, ram_addr, ram_wdata);
        end
    endtask

    task automatic test_contention();
        logic exp_order [5];
        int   g, n_ls, n;
        exp_order = '{OWN_LS, OWN_LS, OWN_LS, OWN_IF, OWN_LS};
        for (int i = 0; i < 5; i++)
            sb.push_back('{own: exp_order[i], data: (exp_order[i] == OWN_IF) ? pat(8'h40) : pat(8'h31)});
        if_addr = 8'h40; ls_addr = 8'h31; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        g = 0; n_ls = 0; n = 0;
        while ((if_req || ls_req || busy) && n < 80) begin
            @(negedge clk);
            n++;
            if (en_ram) begin
                checks++;
                if (g >= 5 || owner !== exp_order[g]) begin
                    errors++;
                    $display("FAIL contention_grant: grant %0d owner=%b, required %b",
                             g, owner, (g < 5) ? exp_order[g] : 1'bx);
                end
                if (g < 5 && owner == OWN_IF) begin
                    checks++;
                    if (dut1.r_streak !== 2'd0) begin
                        errors++;
                        $display("FAIL contention_streak: streak=%0d after IF grant, required 0", dut1.r_streak);
                    end
                end
                g++;
            end
            if (if_ack) if_req = 1'b0;
            if (ls_ack) begin
                n_ls++;
                if (n_ls == 4) ls_req = 1'b0;
            end
        end
        checks++;
        if (g != 5 || n >= 80) begin
            errors++;
            $display("FAIL contention_count: grants=%0d cycles=%0d, required 5 grants within 80", g, n);
        end
        if_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_withdraw();
        int n_en, n_ack;
        if_addr = 8'h44; if_req = 1'b1;
        sb.push_back('{own: OWN_IF, data: pat(8'h44)});
        n_en = 0; n_ack = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) if_req = 1'b0;
            if (en_ram) n_en++;
            if (if_ack) n_ack++;
        end
        checks++;
        if (n_en != 1 || n_ack != 1) begin
            errors++;
            $display("FAIL withdraw: accesses=%0d acks=%0d, required 1 1", n_en, n_ack);
        end
    endtask

    task automatic test_rdlat3();
        ls_addr3 = 8'h05; ls_we3 = 1'b0; ls_req3 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (en_ram3 !== 1'b1 || ram_addr3 !== 8'h05) begin
                    errors++;
                    $display("FAIL lat3_access: en=%b addr=%h, required 1 05", en_ram3, ram_addr3);
                end
            end
            if (k >= 2 && k <= 4) begin
                checks++;
                if (ls_ack3 !== 1'b0 || if_ack3 !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_wait_ack: cycle t+%0d ls_ack=%b, required 0", k, ls_ack3);
                end
            end
            if (k == 5) begin
                checks++;
                if (ls_ack3 !== 1'b1 || ls_rdata3 !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL lat3_ack: ls_ack=%b ls_rdata=%h, required 1 BEEF", ls_ack3, ls_rdata3);
                end
                ls_req3 = 1'b0;
            end
            if (k == 6) begin
                checks++;
                if (busy3 !== 1'b0) begin
                    errors++;
                    $display("FAIL lat3_done: busy=%b, required 0", busy3);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        if_addr = 8'h12; if_req = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({en_ram, wen_ram, if_ack, ls_ack, busy} !== 5'b0 || if_rdata !== 16'h0 || ls_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_read: en/wen/acks/busy=%b ifr=%h lsr=%h, required 0",
                     {en_ram, wen_ram, if_ack, ls_ack, busy}, if_rdata, ls_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ls_addr = 8'h60; ls_we = 1'b1; ls_wdata = 16'h7777; ls_req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({en_ram, wen_ram, ls_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_access: en/wen/ls_ack=%b, required 000", {en_ram, wen_ram, ls_ack});
        end
        ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 16'h0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ls_load(8'h20, pat(8'h20));
        test_ls_store();
        test_ls_load(8'h2F, 16'h1234);
        test_contention();
        test_withdraw();
        test_rdlat3();
        test_reset_mid_op();
        test_if_read();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected acks never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
